// File: rtl/gshare_pkg.sv
// gshare_pkg: shared constants, pending-entry type, FSM states and counter helpers for the gshare predictor
package gshare_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam int IDX_MAX_W = 16;
  localparam int CTR_MAX_W = 8;
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN = 1'b1;
  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic taken;
  } pend_entry_t;
  // Weakly not-taken: one below the taken threshold.
  function automatic logic [CTR_MAX_W-1:0] ctr_init(input int w);
    return CTR_MAX_W'((1 << (w - 1)) - 1);
  endfunction
  // Saturating up/down step; never wraps at either end.
  function automatic logic [CTR_MAX_W-1:0] ctr_sat_update(input logic [CTR_MAX_W-1:0] c, input logic t, input int w);
    logic [CTR_MAX_W-1:0] mx;
    mx = CTR_MAX_W'((1 << w) - 1);
    return t ? ((c == mx) ? c : c + CTR_MAX_W'(1)) : ((c == '0) ? c : c - CTR_MAX_W'(1));
  endfunction
endpackage

// File: rtl/gshare_pend_fifo.sv
// gshare_pend_fifo: in-order queue of in-flight branches; flush clears it before a same-cycle push lands
module gshare_pend_fifo
  import gshare_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  pend_entry_t            din,
  output pend_entry_t            dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
  pend_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign dout = mem[rd];
  assign full = count == FULL_CNT;
  assign empty = count == '0;
  // Pointer/count bookkeeping; on flush the read pointer jumps to the write pointer so only this cycle's push remains.
  always_ff @(posedge clk)
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= wr;
      wr <= wr + PW'(push);
      count <= (PW + 1)'(push);
    end else begin
      rd <= rd + PW'(pop);
      wr <= wr + PW'(push);
      count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
    end
  // Entry storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk)
    if (push) mem[wr] <= din;
endmodule

// File: rtl/gshare_predictor_param.sv
// gshare_predictor_param: gshare branch predictor with sweep-initialised counter table and in-order pending queue
// Optional GSHARE_PERF_CNT_EN adds saturating resolved-branch and mispredict counters.
module gshare_predictor_param
  import gshare_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int GHR_W = 5,
  parameter int CTR_W = 2,
  parameter int PEND_DEPTH = 4,
  parameter int IDX_W = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pred_valid,
  output logic             o_pred_ready,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_instr,
  output logic             o_pred_out_vld,
  output logic             o_pred_br,
  output logic             o_pred_taken,
  output logic [IDX_W-1:0] o_pred_idx,
  input  logic             i_res_valid,
  input  logic             i_res_taken,
  input  logic             i_flush,
  output logic             o_mispredict,
  output logic             o_res_err
`ifdef GSHARE_PERF_CNT_EN
  ,
  output logic [31:0]      o_perf_branches,
  output logic [31:0]      o_perf_mispred
`endif
);
  localparam logic [CTR_MAX_W-1:0] INIT_FULL = ctr_init(CTR_W);
  localparam logic [CTR_W-1:0] INIT_VAL = INIT_FULL[CTR_W-1:0];
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  logic state;
  logic [IDX_W-1:0] sweep;
  logic [GHR_W-1:0] ghr, ghr_n;
  logic [CTR_W-1:0] tbl [ENTRIES];
  logic is_br, acc, push, res_ok, res_err, pred_t, mis;
  logic [IDX_W-1:0] idx, hidx;
  logic [CTR_MAX_W-1:0] upd;
  pend_entry_t head, din;
  logic full, empty;
  logic [$clog2(PEND_DEPTH):0] count;
  logic unused_ok;
  assign is_br = i_instr[6:0] == OPC_BRANCH;
  assign o_pred_ready = (state == ST_RUN) && !full;
  assign acc = i_pred_valid && o_pred_ready;
  assign push = acc && is_br;
  assign res_ok = (state == ST_RUN) && i_res_valid && !empty;
  assign res_err = (state == ST_RUN) && i_res_valid && empty;
  assign hidx = head.idx[IDX_W-1:0];
  assign mis = head.taken != i_res_taken;
  assign unused_ok = ^{i_pc[31:IDX_W+2], i_pc[1:0], i_instr[31:7], head.idx[IDX_MAX_W-1:IDX_W], upd[CTR_MAX_W-1:CTR_W], count};
  // History seen by this cycle's lookup already includes this cycle's resolve; the counter value does not.
  always_comb begin
    ghr_n = res_ok ? GHR_W'({ghr, i_res_taken}) : ghr;
    idx = IDX_W'(ghr_n) ^ i_pc[IDX_W+1:2];
    pred_t = tbl[idx][CTR_W-1];
    upd = ctr_sat_update(CTR_MAX_W'(tbl[hidx]), i_res_taken, CTR_W);
    din = '{idx: IDX_MAX_W'(idx), taken: pred_t};
  end
  // INIT sweeps one entry per cycle then hands over to RUN; GHR shifts in each resolved outcome.
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state <= ST_INIT;
      sweep <= '0;
      ghr <= '0;
    end else begin
      if (state == ST_INIT) begin
        sweep <= sweep + IDX_W'(1);
        if (sweep == LAST_IDX) state <= ST_RUN;
      end
      ghr <= ghr_n;
    end
  // Counter table: initialised by the sweep, trained by resolves of the queue head.
  always_ff @(posedge i_clk)
    if (state == ST_INIT) tbl[sweep] <= INIT_VAL;
    else if (res_ok) tbl[hidx] <= upd[CTR_W-1:0];
  // Registered prediction and resolve responses; everything idles at zero.
  always_ff @(posedge i_clk)
    if (i_reset) begin
      o_pred_out_vld <= 1'b0;
      o_pred_br <= 1'b0;
      o_pred_taken <= 1'b0;
      o_pred_idx <= '0;
      o_mispredict <= 1'b0;
      o_res_err <= 1'b0;
    end else begin
      o_pred_out_vld <= acc;
      o_pred_br <= push;
      o_pred_taken <= push && pred_t;
      o_pred_idx <= push ? idx : '0;
      o_mispredict <= res_ok && mis;
      o_res_err <= res_err;
    end
`ifdef GSHARE_PERF_CNT_EN
  // Saturating event counters; flush leaves them alone.
  always_ff @(posedge i_clk)
    if (i_reset) begin
      o_perf_branches <= '0;
      o_perf_mispred <= '0;
    end else begin
      if (res_ok && o_perf_branches != '1) o_perf_branches <= o_perf_branches + 32'd1;
      if (res_ok && mis && o_perf_mispred != '1) o_perf_mispred <= o_perf_mispred + 32'd1;
    end
`endif
  gshare_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend (
    .clk(i_clk),
    .reset(i_reset),
    .push(push),
    .pop(res_ok),
    .flush(i_flush),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule
